seq_serializer: RTL and testbench

- Parallel-to-serial stage directly upstream of the sequence detector.
- Accepts W-bit words over a valid/ready handshake and drives them MSB-first onto the detector's single-bit `a` input, one bit per clock.
- Back-to-back words stream with no idle cycles between them.
- Marks each bit as live or filler, since the detector shifts on every clock.

---
 rtl/seq_pkg.sv | 15 +
 rtl/seq_serializer_if.sv | 11 +
 rtl/seq_serializer.sv | 135 +++++++++++++
 tb/tb_seq_serializer.sv | 211 +++++++++++++++++++++
 4 files changed

// File: rtl/seq_pkg.sv
// Shared types for the sequence detector / serializer family.
package seq_pkg;

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    PARITY
  } ser_state_t;

  // Counter wide enough to hold 0..w inclusive.
  function automatic int unsigned cnt_width(input int unsigned w);
    return $clog2(w + 1);
  endfunction

endpackage

// File: rtl/seq_serializer_if.sv
// Word handshake into the serializer: producer is master, serializer is slave.
interface seq_serializer_if #(
    parameter int unsigned W = 8
) ();
    logic [W-1:0] in_data;
    logic         in_valid;
    logic         in_ready;

    modport master(output in_data, output in_valid, input in_ready);
    modport slave(input in_data, input in_valid, output in_ready);
endinterface

// File: rtl/seq_serializer.sv
// MSB-first parallel-to-serial stage feeding the sequence detector's `a` input.
// Optional trailing even-parity bit per word when SER_PARITY_EN is defined.
module seq_serializer
    import seq_pkg::*;
#(
    parameter int unsigned W        = 8,
    parameter logic        IDLE_BIT = 1'b0
) (
    input  logic             clk,
    input  logic             reset,
    seq_serializer_if.slave  in_if,
    output logic             a,
    output logic             a_valid,
    output logic             sof,
    output logic             busy
);

    localparam int unsigned     CntW    = cnt_width(W);
    localparam logic [CntW-1:0] LastCnt = CntW'(W - 1);

    ser_state_t      state_q;
    logic [W-1:0]    sh_q;
    logic [W-1:0]    hold_q;
    logic [CntW-1:0] cnt_q;
    logic            hold_full_q;
    logic            a_q;
    logic            a_valid_q;
    logic            sof_q;
`ifdef SER_PARITY_EN
    logic            par_q;
`endif

    logic            accept;
    logic            has_next;
    logic [W-1:0]    next_word;

    // A pending held word always wins the handoff over a fresh input word.
    always_comb begin
        accept    = in_if.in_valid && !hold_full_q;
        has_next  = hold_full_q || accept;
        next_word = hold_full_q ? hold_q : in_if.in_data;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            sh_q        <= '0;
            hold_q      <= '0;
            cnt_q       <= '0;
            hold_full_q <= 1'b0;
            a_q         <= IDLE_BIT;
            a_valid_q   <= 1'b0;
            sof_q       <= 1'b0;
`ifdef SER_PARITY_EN
            par_q       <= 1'b0;
`endif
        end else begin
            case (state_q)
                IDLE: begin
                    a_q       <= IDLE_BIT;
                    a_valid_q <= 1'b0;
                    sof_q     <= 1'b0;
                    if (accept) begin
                        sh_q    <= in_if.in_data;
                        cnt_q   <= '0;
                        state_q <= SHIFT;
`ifdef SER_PARITY_EN
                        par_q   <= ^in_if.in_data;
`endif
                    end
                end

                SHIFT: begin
                    a_q       <= sh_q[W-1];
                    a_valid_q <= 1'b1;
                    sof_q     <= (cnt_q == '0);
                    sh_q      <= {sh_q[W-2:0], 1'b0};
                    cnt_q     <= cnt_q + CntW'(1);
                    if (cnt_q == LastCnt) begin
`ifdef SER_PARITY_EN
                        state_q <= PARITY;
                        if (accept) begin
                            hold_q      <= in_if.in_data;
                            hold_full_q <= 1'b1;
                        end
`else
                        if (has_next) begin
                            sh_q        <= next_word;
                            cnt_q       <= '0;
                            hold_full_q <= 1'b0;
                            state_q     <= SHIFT;
                        end else begin
                            state_q <= IDLE;
                        end
`endif
                    end else if (accept) begin
                        hold_q      <= in_if.in_data;
                        hold_full_q <= 1'b1;
                    end
                end

`ifdef SER_PARITY_EN
                PARITY: begin
                    a_q       <= par_q;
                    a_valid_q <= 1'b1;
                    sof_q     <= 1'b0;
                    if (has_next) begin
                        sh_q        <= next_word;
                        cnt_q       <= '0;
                        hold_full_q <= 1'b0;
                        par_q       <= ^next_word;
                        state_q     <= SHIFT;
                    end else begin
                        state_q <= IDLE;
                    end
                end
`endif

                default: begin
                    a_q       <= IDLE_BIT;
                    a_valid_q <= 1'b0;
                    sof_q     <= 1'b0;
                    state_q   <= IDLE;
                end
            endcase
        end
    end

    assign in_if.in_ready = !hold_full_q;
    assign a              = a_q;
    assign a_valid        = a_valid_q;
    assign sof            = sof_q;
    assign busy           = (state_q != IDLE) || hold_full_q;

endmodule

// File: tb/tb_seq_serializer.sv
// Directed bench for seq_serializer: W=8 main instance plus a W=6 instance
// whose serial stream is checked against the detector pattern.
module tb_seq_serializer;

    logic clk = 1'b0;
    logic reset = 1'b1;

    logic a8, a8_valid, sof8, busy8;
    logic a6, a6_valid, sof6, busy6;

    seq_serializer_if #(.W(8)) bus8 ();
    seq_serializer_if #(.W(6)) bus6 ();

    seq_serializer #(.W(8), .IDLE_BIT(1'b0)) dut (
        .clk     (clk),
        .reset   (reset),
        .in_if   (bus8),
        .a       (a8),
        .a_valid (a8_valid),
        .sof     (sof8),
        .busy    (busy8)
    );

    seq_serializer #(.W(6), .IDLE_BIT(1'b0)) dut6 (
        .clk     (clk),
        .reset   (reset),
        .in_if   (bus6),
        .a       (a6),
        .a_valid (a6_valid),
        .sof     (sof6),
        .busy    (busy6)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
    endtask

    logic [7:0]  exp1;
    logic [15:0] exp2;
    logic [23:0] exp3;
    logic [17:0] expp;
    logic [5:0]  win;
    int          nbits;

    initial begin
        bus8.in_data  = '0;
        bus8.in_valid = 1'b0;
        bus6.in_data  = '0;
        bus6.in_valid = 1'b0;

        do_reset();
        check_eq("rst_a", a8, 0);
        check_eq("rst_a_valid", a8_valid, 0);
        check_eq("rst_sof", sof8, 0);
        check_eq("rst_busy", busy8, 0);
        check_eq("rst_in_ready", bus8.in_ready, 1);

`ifndef SER_PARITY_EN
        // Single word A5, accepted at edge t; bits on edges t+1..t+8.
        exp1 = 8'b10100101;
        bus8.in_data  = 8'hA5;
        bus8.in_valid = 1'b1;
        tick();
        bus8.in_valid = 1'b0;
        check_eq("single_latency_a_valid", a8_valid, 0);
        for (int i = 1; i <= 8; i++) begin
            tick();
            check_eq($sformatf("single_bit%0d", i), a8, exp1[8-i]);
            check_eq($sformatf("single_valid%0d", i), a8_valid, 1);
            check_eq($sformatf("single_sof%0d", i), sof8, (i == 1));
        end
        tick();
        check_eq("single_end_a_valid", a8_valid, 0);
        check_eq("single_end_busy", busy8, 0);
        check_eq("single_end_a", a8, 0);

        // Back-to-back A5, 3C: 16 contiguous bits, sof spacing 8.
        do_reset();
        exp2 = 16'b1010010100111100;
        bus8.in_data  = 8'hA5;
        bus8.in_valid = 1'b1;
        tick();
        bus8.in_data = 8'h3C;
        for (int i = 1; i <= 16; i++) begin
            tick();
            if (i == 1) bus8.in_valid = 1'b0;
            check_eq($sformatf("b2b_bit%0d", i), a8, exp2[16-i]);
            check_eq($sformatf("b2b_valid%0d", i), a8_valid, 1);
            check_eq($sformatf("b2b_sof%0d", i), sof8, (i == 1 || i == 9));
        end
        tick();
        check_eq("b2b_end_a_valid", a8_valid, 0);
        check_eq("b2b_end_a", a8, 0);

        // Backpressure: three words with in_valid held.
        do_reset();
        exp3 = 24'b101001010011110011110000;
        bus8.in_data  = 8'hA5;
        bus8.in_valid = 1'b1;
        tick();
        check_eq("bp_rdy_after_first", bus8.in_ready, 1);
        bus8.in_data = 8'h3C;
        for (int i = 1; i <= 24; i++) begin
            tick();
            if (i == 1) bus8.in_data = 8'hF0;
            if (i == 9) bus8.in_valid = 1'b0;
            check_eq($sformatf("bp_bit%0d", i), a8, exp3[24-i]);
            check_eq($sformatf("bp_valid%0d", i), a8_valid, 1);
            check_eq($sformatf("bp_sof%0d", i), sof8, (i == 1 || i == 9 || i == 17));
            if (i == 1 || i == 7 || i == 9 || i == 15)
                check_eq($sformatf("bp_rdy_low%0d", i), bus8.in_ready, 0);
            if (i == 8 || i == 16)
                check_eq($sformatf("bp_rdy_high%0d", i), bus8.in_ready, 1);
        end
        tick();
        check_eq("bp_end_a_valid", a8_valid, 0);
        check_eq("bp_end_busy", busy8, 0);

        // Reset mid-word with a second word sitting in hold.
        do_reset();
        bus8.in_data  = 8'hFF;
        bus8.in_valid = 1'b1;
        tick();
        tick();
        bus8.in_valid = 1'b0;
        tick();
        tick();
        check_eq("mid_pre_busy", busy8, 1);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check_eq("mid_a_valid", a8_valid, 0);
        check_eq("mid_a", a8, 0);
        check_eq("mid_in_ready", bus8.in_ready, 1);
        check_eq("mid_busy", busy8, 0);
        exp1 = 8'b10000001;
        bus8.in_data  = 8'h81;
        bus8.in_valid = 1'b1;
        tick();
        bus8.in_valid = 1'b0;
        for (int i = 1; i <= 8; i++) begin
            tick();
            check_eq($sformatf("mid_bit%0d", i), a8, exp1[8-i]);
            check_eq($sformatf("mid_sof%0d", i), sof8, (i == 1));
        end
        tick();
        check_eq("mid_end_a_valid", a8_valid, 0);

        // W=6 stream into a detector-style window, pattern 101101.
        do_reset();
        win   = '0;
        nbits = 0;
        bus6.in_data  = 6'b101101;
        bus6.in_valid = 1'b1;
        tick();
        bus6.in_valid = 1'b0;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (a6_valid) begin
                win   = {win[4:0], a6};
                nbits = nbits + 1;
            end
        end
        check_eq("det6_nbits", nbits, 6);
        check_eq("det6_window", win, 6'b101101);
        check_eq("det6_busy", busy6, 0);
`else
        // Parity build: A5 then 07, each 8 data bits plus even parity.
        expp = 18'b10100101_0_00000111_1;
        bus8.in_data  = 8'hA5;
        bus8.in_valid = 1'b1;
        tick();
        bus8.in_data = 8'h07;
        for (int i = 1; i <= 18; i++) begin
            tick();
            if (i == 1) bus8.in_valid = 1'b0;
            check_eq($sformatf("par_bit%0d", i), a8, expp[18-i]);
            check_eq($sformatf("par_valid%0d", i), a8_valid, 1);
            check_eq($sformatf("par_sof%0d", i), sof8, (i == 1 || i == 10));
        end
        tick();
        check_eq("par_end_a_valid", a8_valid, 0);
        check_eq("par_end_busy", busy8, 0);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
